// File: rtl/alu_pkg.sv
// Shared ALU definitions for the ID/EX stage: ALU control codes, alu_op
// encodings, R-type funct codes and the bubble control word.
package alu_pkg;

  // Codes driven onto the ALU's ALUControl input
  localparam logic [3:0] ALU_CTRL_AND     = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR      = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD     = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB     = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT     = 4'b0111;
  localparam logic [3:0] ALU_CTRL_INVALID = 4'b1111;

  // Main-decoder alu_op encodings
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_AND   = 2'b11;

  // R-type funct field encodings
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Control bits that must be cleared to turn a slot into a bubble
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0,
                                       mem_read: 1'b0, mem_write: 1'b0};

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control decoder: maps alu_op and, for R-type
// instructions, the funct field onto a 4-bit ALUControl code.
import alu_pkg::*;

module alu_control (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);

  // Decode alu_op first; only R-type consults funct, unknown functs map to INVALID
  always_comb begin
    alu_ctrl = ALU_CTRL_INVALID;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_CTRL_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_CTRL_SUB;
      ALU_OP_AND: alu_ctrl = ALU_CTRL_AND;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_CTRL_ADD;
          FUNCT_SUB: alu_ctrl = ALU_CTRL_SUB;
          FUNCT_AND: alu_ctrl = ALU_CTRL_AND;
          FUNCT_OR:  alu_ctrl = ALU_CTRL_OR;
          FUNCT_SLT: alu_ctrl = ALU_CTRL_SLT;
          default:   alu_ctrl = ALU_CTRL_INVALID;
        endcase
      end
      default: alu_ctrl = ALU_CTRL_INVALID;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and
// load-use hazard detection.
// Build option: define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB
// forwarding plus load-use detection; without it the operands come straight
// from the registered register-file data and load_use_hazard is tied low.
import alu_pkg::*;

module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic [1:0]       id_alu_op,
  input  logic [5:0]       id_funct,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [3:0]       ex_alu_control,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             load_use_hazard
);

  ex_ctrl_t         ctrl_q;
  logic [3:0]       alu_ctrl_q;
  logic [XLEN-1:0]  rs_data_q;
  logic [XLEN-1:0]  rt_data_q;
  logic [XLEN-1:0]  imm_q;
  logic [RADDR-1:0] rs_q;
  logic [RADDR-1:0] rt_q;
  logic [RADDR-1:0] rd_q;
  logic             alu_src_q;
  logic [3:0]       alu_ctrl_d;
  logic [XLEN-1:0]  fwd_rs;
  logic [XLEN-1:0]  fwd_rt;

  alu_control u_alu_control (
    .alu_op   (id_alu_op),
    .funct    (id_funct),
    .alu_ctrl (alu_ctrl_d)
  );

`ifdef ID_EX_FORWARDING_EN
  // A load in EX whose destination feeds the instruction in ID cannot be
  // forwarded in time, so flag it; reset forces the flag low
  assign load_use_hazard = ~reset & ctrl_q.valid & ctrl_q.mem_read &
                           (rd_q != '0) & id_valid &
                           ((rd_q == id_rs) | (rd_q == id_rt));

  // Pick the youngest producer for each source; EX/MEM beats MEM/WB, r0 never forwards
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_rs = memwb_result;

    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_rt = memwb_result;
  end
`else
  logic unused_fwd;

  assign load_use_hazard = 1'b0;
  assign fwd_rs          = rs_data_q;
  assign fwd_rt          = rt_data_q;
  assign unused_fwd      = ^{exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_result,
                             rs_q, rt_q};
`endif

  // Pipeline register: flush and load-use insert a bubble, stall holds, otherwise load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= CTRL_BUBBLE;
      alu_ctrl_q <= 4'b0000;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      alu_src_q  <= 1'b0;
    end else if (flush || load_use_hazard) begin
      ctrl_q <= CTRL_BUBBLE;
    end else if (!stall) begin
      ctrl_q.valid     <= id_valid;
      ctrl_q.reg_write <= id_reg_write;
      ctrl_q.mem_read  <= id_mem_read;
      ctrl_q.mem_write <= id_mem_write;
      alu_ctrl_q       <= alu_ctrl_d;
      rs_data_q        <= id_rs_data;
      rt_data_q        <= id_rt_data;
      imm_q            <= id_imm;
      rs_q             <= id_rs;
      rt_q             <= id_rt;
      rd_q             <= id_rd;
      alu_src_q        <= id_alu_src;
    end
  end

  assign ex_valid       = ctrl_q.valid;
  assign ex_reg_write   = ctrl_q.valid & ctrl_q.reg_write;
  assign ex_mem_read    = ctrl_q.valid & ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.valid & ctrl_q.mem_write;
  assign ex_alu_control = alu_ctrl_q;
  assign ex_rd          = rd_q;
  assign ex_a           = fwd_rs;
  assign ex_store_data  = fwd_rt;
  assign ex_b           = alu_src_q ? imm_q : fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Expected values follow the
// ID_EX_FORWARDING_EN setting of the build.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0;
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_op = 2'b00; id_funct = 6'd0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rs_data = 32'h1111; id_alu_op = 2'b01; id_rd = 5'd9;
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid); end
    checks++; if (ex_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_a: got %h expected 0", ex_a); end
    checks++; if (ex_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_b: got %h expected 0", ex_b); end
    checks++; if (ex_alu_control !== 4'b0000) begin errors++; $display("[TB] FAIL reset_aluctl: got %b expected 0000", ex_alu_control); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd: got %0d expected 0", ex_rd); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {ex_reg_write, ex_mem_read, ex_mem_write}); end
    checks++; if (load_use_hazard !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %b expected 0", load_use_hazard); end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    step();
  endtask

  task automatic test_alu_decode();
    logic [1:0] ops [10];
    logic [5:0] fns [10];
    logic [3:0] exp [10];
    ops[0] = 2'b00; fns[0] = 6'b101010; exp[0] = 4'b0010;
    ops[1] = 2'b01; fns[1] = 6'b100100; exp[1] = 4'b0110;
    ops[2] = 2'b11; fns[2] = 6'b100000; exp[2] = 4'b0000;
    ops[3] = 2'b10; fns[3] = 6'b100000; exp[3] = 4'b0010;
    ops[4] = 2'b10; fns[4] = 6'b100010; exp[4] = 4'b0110;
    ops[5] = 2'b10; fns[5] = 6'b100100; exp[5] = 4'b0000;
    ops[6] = 2'b10; fns[6] = 6'b100101; exp[6] = 4'b0001;
    ops[7] = 2'b10; fns[7] = 6'b101010; exp[7] = 4'b0111;
    ops[8] = 2'b10; fns[8] = 6'b000000; exp[8] = 4'b1111;
    ops[9] = 2'b10; fns[9] = 6'b101011; exp[9] = 4'b1111;
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      id_valid = 1; id_alu_op = ops[i]; id_funct = fns[i];
      id_rs_data = 32'h100 + i;
      step();
      checks++; if (ex_alu_control !== exp[i]) begin errors++; $display("[TB] FAIL decode_%0d: got %b expected %b", i, ex_alu_control, exp[i]); end
      checks++; if (ex_a !== 32'h100 + i) begin errors++; $display("[TB] FAIL decode_a_%0d: got %h expected %h", i, ex_a, 32'h100 + i); end
    end
    // slt rs=5 rt=9 with no hazards
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_alu_op = 2'b10; id_funct = 6'b101010;
    id_rs_data = 32'd5; id_rt_data = 32'd9; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    step();
    checks++; if (ex_alu_control !== 4'b0111) begin errors++; $display("[TB] FAIL slt_ctl: got %b expected 0111", ex_alu_control); end
    checks++; if (ex_a !== 32'd5) begin errors++; $display("[TB] FAIL slt_a: got %h expected 5", ex_a); end
    checks++; if (ex_b !== 32'd9) begin errors++; $display("[TB] FAIL slt_b: got %h expected 9", ex_b); end
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL slt_valid: got %b expected 1", ex_valid); end
    checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("[TB] FAIL slt_regwrite: got %b expected 1", ex_reg_write); end
  endtask

  task automatic test_alu_src();
    clear_inputs();
    id_valid = 1; id_alu_src = 1; id_mem_write = 1; id_imm = 32'hFFFF_FFF0;
    id_rt_data = 32'd7; id_rs_data = 32'd40; id_rs = 5'd6; id_rt = 5'd7;
    step();
    checks++; if (ex_b !== 32'hFFFF_FFF0) begin errors++; $display("[TB] FAIL alusrc_b: got %h expected fffffff0", ex_b); end
    checks++; if (ex_store_data !== 32'd7) begin errors++; $display("[TB] FAIL alusrc_store: got %h expected 7", ex_store_data); end
    checks++; if (ex_mem_write !== 1'b1) begin errors++; $display("[TB] FAIL alusrc_memwrite: got %b expected 1", ex_mem_write); end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp;
    clear_inputs();
    id_valid = 1; id_rs = 5'd3; id_rt = 5'd3; id_rs_data = 32'h11; id_rt_data = 32'h22;
    step();
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h1234;
    #1;
    exp = FWD ? 32'hAAAA_0000 : 32'h11;
    checks++; if (ex_a !== exp) begin errors++; $display("[TB] FAIL fwd_both_a: got %h expected %h", ex_a, exp); end
    exp = FWD ? 32'hAAAA_0000 : 32'h22;
    checks++; if (ex_b !== exp) begin errors++; $display("[TB] FAIL fwd_both_b: got %h expected %h", ex_b, exp); end
    checks++; if (ex_store_data !== exp) begin errors++; $display("[TB] FAIL fwd_both_store: got %h expected %h", ex_store_data, exp); end
    exmem_reg_write = 0;
    #1;
    exp = FWD ? 32'h1234 : 32'h11;
    checks++; if (ex_a !== exp) begin errors++; $display("[TB] FAIL fwd_memwb_a: got %h expected %h", ex_a, exp); end
    memwb_reg_write = 0;
    exmem_reg_write = 1; exmem_rd = 5'd4;
    #1;
    checks++; if (ex_a !== 32'h11) begin errors++; $display("[TB] FAIL fwd_nomatch_a: got %h expected 11", ex_a); end
    // Only rt matches, from MEM/WB
    clear_inputs();
    id_valid = 1; id_rs = 5'd3; id_rt = 5'd8; id_rs_data = 32'h33; id_rt_data = 32'h44;
    id_alu_src = 1; id_imm = 32'h8;
    step();
    memwb_reg_write = 1; memwb_rd = 5'd8; memwb_result = 32'hBEEF;
    #1;
    exp = FWD ? 32'hBEEF : 32'h44;
    checks++; if (ex_store_data !== exp) begin errors++; $display("[TB] FAIL fwd_rt_store: got %h expected %h", ex_store_data, exp); end
    checks++; if (ex_a !== 32'h33) begin errors++; $display("[TB] FAIL fwd_rt_a: got %h expected 33", ex_a); end
    checks++; if (ex_b !== 32'h8) begin errors++; $display("[TB] FAIL fwd_rt_b: got %h expected 8", ex_b); end
    // Register 0 is never forwarded
    clear_inputs();
    id_valid = 1; id_rs = 5'd0; id_rs_data = 32'h55;
    step();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hFFFF_FFFF;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hFFFF_FFFF;
    #1;
    checks++; if (ex_a !== 32'h55) begin errors++; $display("[TB] FAIL fwd_r0_a: got %h expected 55", ex_a); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd4; id_rs = 5'd1; id_rt = 5'd2;
    step();
    checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("[TB] FAIL lw_memread: got %b expected 1", ex_mem_read); end
    id_mem_read = 0; id_rs = 5'd5; id_rt = 5'd4; id_rd = 5'd6; id_valid = 0;
    #1;
    checks++; if (load_use_hazard !== 1'b0) begin errors++; $display("[TB] FAIL lu_idinvalid: got %b expected 0", load_use_hazard); end
    id_valid = 1;
    #1;
    checks++; if (load_use_hazard !== FWD) begin errors++; $display("[TB] FAIL lu_hazard: got %b expected %b", load_use_hazard, FWD); end
    step();
    checks++; if (ex_valid !== !FWD) begin errors++; $display("[TB] FAIL lu_bubble_valid: got %b expected %b", ex_valid, !FWD); end
    checks++; if (ex_reg_write !== !FWD) begin errors++; $display("[TB] FAIL lu_bubble_regwrite: got %b expected %b", ex_reg_write, !FWD); end
    step();
    checks++; if (ex_rd !== 5'd6 || ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL lu_reload: got rd %0d valid %b expected rd 6 valid 1", ex_rd, ex_valid); end
    // A load targeting r0 never raises the hazard
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_rd = 5'd0;
    step();
    id_mem_read = 0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checks++; if (load_use_hazard !== 1'b0) begin errors++; $display("[TB] FAIL lu_r0: got %b expected 0", load_use_hazard); end
    clear_inputs();
    step();
  endtask

  task automatic test_flush_stall();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_rd = 5'd9;
    step();
    flush = 1; stall = 1;
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", ex_valid); end
    checks++; if ({ex_reg_write, ex_mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL flush_ctrl: got %b expected 00", {ex_reg_write, ex_mem_write}); end
    flush = 0; stall = 0;
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_recover: got %b expected 1", ex_valid); end
  endtask

  task automatic test_stall();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rs_data = 32'h100; id_rd = 5'd7; id_alu_op = 2'b00;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_rs_data = 32'h200 + i; id_rd = 5'd10 + 5'(i); id_alu_op = 2'b01; id_valid = i[0];
      step();
      checks++; if (ex_a !== 32'h100 || ex_rd !== 5'd7 || ex_alu_control !== 4'b0010 || ex_valid !== 1'b1)
        begin errors++; $display("[TB] FAIL stall_hold_%0d: got a %h rd %0d ctl %b valid %b expected a 100 rd 7 ctl 0010 valid 1", i, ex_a, ex_rd, ex_alu_control, ex_valid); end
    end
    stall = 0;
    step();
    checks++; if (ex_a !== 32'h202 || ex_rd !== 5'd12 || ex_alu_control !== 4'b0110)
      begin errors++; $display("[TB] FAIL stall_release: got a %h rd %0d ctl %b expected a 202 rd 12 ctl 0110", ex_a, ex_rd, ex_alu_control); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rs_data = 32'h77; id_alu_op = 2'b01; id_rd = 5'd5;
    step();
    #3 reset = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_a !== 32'h0 || ex_alu_control !== 4'b0000 || ex_rd !== 5'd0)
      begin errors++; $display("[TB] FAIL reset_mid_clear: got valid %b a %h ctl %b rd %0d expected all 0", ex_valid, ex_a, ex_alu_control, ex_rd); end
    checks++; if (ex_reg_write !== 1'b0 || load_use_hazard !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_mid_ctrl: got regwrite %b hazard %b expected 0 0", ex_reg_write, load_use_hazard); end
    #2 reset = 1'b0;
    step();
    checks++; if (ex_valid !== 1'b1 || ex_a !== 32'h77 || ex_alu_control !== 4'b0110 || ex_rd !== 5'd5)
      begin errors++; $display("[TB] FAIL reset_mid_reload: got valid %b a %h ctl %b rd %0d expected 1 77 0110 5", ex_valid, ex_a, ex_alu_control, ex_rd); end
  endtask

  initial begin
    test_reset();
    test_alu_decode();
    test_alu_src();
    test_forwarding();
    test_load_use();
    test_flush_stall();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
